// File: rtl/switch_input_ctrl.sv
// switch_input_ctrl
// Memory-mapped input peripheral for the board's 8 slide switches.
// The raw bus passes through a two-flop synchronizer and a whole-word debouncer.
// Each newly settled value is captured in a snapshot register and raises
// pending, plus overrun if a previous value was never collected.
// Register map (word select i_addr):
//   0 : debounced value  {24'b0, stable}
//   1 : status           {29'b0, overrun, irq_en, pending}  (writable)
//   2 : snapshot         {24'b0, snapshot}, reading it clears pending/overrun
//   3 : reserved, reads 0, writes ignored
// Read data is combinational to fit the CPU's single-cycle load path.

module switch_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_switch,
  input  logic [1:0]  i_addr,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  localparam logic [1:0] ADDR_VALUE    = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_SNAPSHOT = 2'd2;

  // Terminal count: the counter reaches it after DEBOUNCE_CYCLES-1 increments,
  // so the candidate must sit on sync2 for DEBOUNCE_CYCLES+1 cycles in total.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [7:0]           r_sync1;
  logic [7:0]           r_sync2;
  logic [7:0]           r_cand;
  logic [7:0]           r_stable;
  logic [7:0]           r_snapshot;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_pending;
  logic                 r_overrun;
  logic                 r_irq_en;

  logic                 w_accept;
  logic                 w_status_wr;
  logic                 w_clear;

  // Accept fires when the candidate has survived the full window unchanged.
  assign w_accept = (r_sync2 != r_stable) &&
                    (r_sync2 == r_cand) &&
                    (r_cnt == CNT_LAST);

  assign w_status_wr = i_wr && (i_addr == ADDR_STATUS);

  // Either W1C on bit0 of status or a read of the snapshot collects the event.
  assign w_clear = (w_status_wr && i_wdata[0]) ||
                   (i_rd && (i_addr == ADDR_SNAPSHOT));

  // Two-flop synchronizer for the asynchronous switch bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_switch;
      r_sync2 <= r_sync1;
    end
  end

  // Whole-word debouncer: any bit change restarts the stability count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cand     <= '0;
      r_stable   <= '0;
      r_snapshot <= '0;
      r_cnt      <= '0;
    end else begin
      if (r_sync2 == r_stable) begin
        r_cnt  <= '0;
        r_cand <= r_stable;
      end else if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable   <= r_cand;
        r_snapshot <= r_cand;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Status flags: a new accept beats a simultaneous clear, but the clear
  // still wipes overrun because the CPU has just collected the old value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_clear) begin
        r_pending <= w_accept;
        r_overrun <= 1'b0;
      end else if (w_accept) begin
        r_pending <= 1'b1;
        r_overrun <= r_overrun | r_pending;
      end
    end
  end

  // Interrupt enable lives in bit1 of the status word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq_en <= 1'b0;
    end else if (w_status_wr) begin
      r_irq_en <= i_wdata[1];
    end
  end

  assign o_irq = r_pending & r_irq_en;

  // Combinational read mux; reserved word reads as zero.
  always_comb begin
    o_rdata = '0;
    case (i_addr)
      ADDR_VALUE:    o_rdata = {24'b0, r_stable};
      ADDR_STATUS:   o_rdata = {29'b0, r_overrun, r_irq_en, r_pending};
      ADDR_SNAPSHOT: o_rdata = {24'b0, r_snapshot};
      default:       o_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed bench for switch_input_ctrl with a short debounce window (4).

module tb_switch_input_ctrl;

  localparam int unsigned DEB = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_switch;
  logic [1:0]  i_addr;
  logic        i_rd;
  logic        i_wr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_irq;

  int n_checks = 0;
  int n_pass   = 0;

  switch_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH(4)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_switch(i_switch),
    .i_addr(i_addr),
    .i_rd(i_rd),
    .i_wr(i_wr),
    .i_wdata(i_wdata),
    .o_rdata(o_rdata),
    .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
    i_addr = a;
    #1;
    chk(tag, o_rdata, exp);
  endtask

  // Advance one rising edge, land 1 time unit after it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    i_addr  = a;
    i_wdata = d;
    i_wr    = 1'b1;
    step();
    i_wr    = 1'b0;
  endtask

  task automatic bus_read_clear();
    i_addr = 2'd2;
    i_rd   = 1'b1;
    step();
    i_rd   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n  = 1'b0;
    i_switch = 8'h4A;
    i_addr   = 2'd0;
    i_rd     = 1'b0;
    i_wr     = 1'b0;
    i_wdata  = '0;

    // Power-up: reset held for 3 cycles with switches at 0x4A.
    step();
    for (int a = 0; a < 4; a++) rd_chk(2'(a), 32'h0, "rst_rdata");
    chk("rst_irq", 32'(o_irq), 32'h0);
    steps(2);
    i_rst_n = 1'b1;
    i_addr  = 2'd0;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("pwr_early", o_rdata, 32'h0);
    end
    step();
    rd_chk(2'd0, 32'h4A, "pwr_value");
    rd_chk(2'd1, 32'h1,  "pwr_status");
    rd_chk(2'd2, 32'h4A, "pwr_snap");
    chk("pwr_irq", 32'(o_irq), 32'h0);

    // Glitch: 0x4B for 3 cycles then back to 0x4A.
    i_switch = 8'h4B;
    steps(3);
    i_switch = 8'h4A;
    step();
    chk("glitch_cnt_mid", 32'(dut.r_cnt), 32'h1);
    steps(4);
    rd_chk(2'd0, 32'h4A, "glitch_value");
    rd_chk(2'd1, 32'h1,  "glitch_status");
    rd_chk(2'd2, 32'h4A, "glitch_snap");
    chk("glitch_cnt", 32'(dut.r_cnt), 32'h0);

    // Collect the power-up event before the bounce run.
    bus_read_clear();
    rd_chk(2'd1, 32'h0, "rdclr_status");

    // Bounce: 10 alternating cycles, final value 0xFF held.
    for (int i = 0; i < 10; i++) begin
      i_switch = (i % 2 == 0) ? 8'h00 : 8'hFF;
      if (i != 9) step();
    end
    i_addr = 2'd0;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("bounce_early", o_rdata, 32'h4A);
    end
    step();
    rd_chk(2'd0, 32'hFF, "bounce_value");
    rd_chk(2'd1, 32'h1,  "bounce_status");

    // IRQ path.
    bus_write(2'd1, 32'h2);
    chk("irq_on", 32'(o_irq), 32'h1);
    rd_chk(2'd1, 32'h3, "irq_status");
    bus_read_clear();
    rd_chk(2'd1, 32'h2, "irq_clr_status");
    chk("irq_off", 32'(o_irq), 32'h0);

    // Overrun: two accepts without a clear.
    i_switch = 8'h10;
    steps(DEB + 3);
    rd_chk(2'd2, 32'h10, "ovr_snap1");
    rd_chk(2'd1, 32'h3,  "ovr_status1");
    i_switch = 8'h20;
    steps(DEB + 3);
    rd_chk(2'd1, 32'h7,  "ovr_status2");
    rd_chk(2'd2, 32'h20, "ovr_snap2");
    chk("ovr_irq", 32'(o_irq), 32'h1);
    bus_write(2'd1, 32'h3);
    rd_chk(2'd1, 32'h2, "ovr_w1c");
    chk("ovr_irq_off", 32'(o_irq), 32'h0);

    // W1C on the same edge as an accept, with pending already set.
    i_switch = 8'h40;
    steps(DEB + 3);
    rd_chk(2'd1, 32'h3, "sim_pre");
    i_switch = 8'h50;
    steps(DEB + 2);
    bus_write(2'd1, 32'h3);
    rd_chk(2'd1, 32'h3,  "sim_w1c_status");
    rd_chk(2'd0, 32'h50, "sim_w1c_value");

    // Read-clear on the same edge as an accept.
    i_switch = 8'h60;
    steps(DEB + 2);
    bus_read_clear();
    rd_chk(2'd1, 32'h3,  "sim_rd_status");
    rd_chk(2'd2, 32'h60, "sim_rd_snap");

    // wdata[2] ignored; addr 3 inert.
    bus_write(2'd1, 32'h4);
    rd_chk(2'd1, 32'h1, "wr_bit2_ignored");
    bus_write(2'd3, 32'hFFFF_FFFF);
    rd_chk(2'd1, 32'h1, "addr3_wr_status");
    rd_chk(2'd3, 32'h0, "addr3_read");

    // Reset mid-debounce at cnt = 2.
    i_switch = 8'h70;
    steps(5);
    chk("rstmid_cnt_pre", 32'(dut.r_cnt), 32'h2);
    i_rst_n = 1'b0;
    #1;
    chk("rstmid_cnt", 32'(dut.r_cnt), 32'h0);
    chk("rstmid_cand", 32'(dut.r_cand), 32'h0);
    for (int a = 0; a < 4; a++) rd_chk(2'(a), 32'h0, "rstmid_rdata");
    chk("rstmid_irq", 32'(o_irq), 32'h0);
    step();
    i_rst_n = 1'b1;
    i_addr  = 2'd0;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("rerun_early", o_rdata, 32'h0);
    end
    step();
    rd_chk(2'd0, 32'h70, "rerun_value");
    rd_chk(2'd1, 32'h1,  "rerun_status");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_input_ctrl.md
# switch_input_ctrl

Memory-mapped input peripheral carrying the board's 8 slide switches into the single-cycle MIPS CPU, the input counterpart to the CPU's LED/seven-segment output path. It synchronizes and debounces the raw switch bus and captures each newly settled value in a snapshot register. It flags changes through a pending/overrun status word and a maskable interrupt. The CPU reads it through a combinational read port, matching the CPU's single-cycle load path.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized cycles required to accept a new value; must be ≥ 2.
- CNT_WIDTH, 16: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- switch  in  8  raw switch bus, asynchronous to clk.
- addr  in  2  word select: 0 = debounced value, 1 = status, 2 = snapshot, 3 = reserved.
- rd  in  1  read strobe; side effects occur at the clock edge.
- wr  in  1  write strobe.
- wdata  in  32  write data; only addr 1 is writable.
- rdata  out  32  combinational read data for the current addr.
- irq  out  1  interrupt request, level: pending & irq_en.

## Operation
- Synchronizer: two flops, sync1 <= switch and sync2 <= sync1.
- Debounce registers: cand[7:0], stable[7:0], cnt[CNT_WIDTH-1:0]. Each edge, the first matching rule applies:
  - sync2 == stable: cnt <= 0, cand <= stable.
  - sync2 != cand: cand <= sync2, cnt <= 0.
  - cnt == DEBOUNCE_CYCLES-1: stable <= cand, snapshot <= cand, cnt <= 0, accept event.
  - otherwise: cnt <= cnt+1.
- The whole bus is debounced as one word. Any bit change restarts the count.
- Accept event sets pending. If pending is already 1 and is not being cleared in the same cycle, it also sets overrun.
- Status word (addr 1): bit0 pending, bit1 irq_en, bit2 overrun, all other bits 0.
- Write to addr 1:
  - irq_en <= wdata[1].
  - wdata[0] = 1 clears pending and overrun (W1C).
  - wdata[2] is ignored.
- Read-clear: rd with addr 2 clears pending and overrun at the edge.
- Set and clear in the same edge (accept event plus W1C or read-clear): the set wins. Pending stays 1, overrun becomes 0.
- Reads of addr 0 and addr 2 return {24'b0, value}. Addr 3 reads 0, and writes to it are ignored. rd and wr may be asserted together; both effects apply.

## Timing
- Reset values: sync1, sync2, cand, stable, cnt, snapshot, pending, overrun and irq_en are all 0.
  - So irq = 0 and rdata = 0 for every addr while reset is low.
- Latency: a raw value first sampled at edge 1 and held appears in stable and snapshot after edge DEBOUNCE_CYCLES+3. Pending sets on that same edge, and irq rises in that cycle if irq_en = 1.
- A change shorter than DEBOUNCE_CYCLES+1 synchronized cycles is rejected: stable, snapshot and pending are unchanged.
- rdata is combinational from addr and the registers. Register updates are visible on rdata after the edge.
- Status clears take effect at the edge where the strobe is sampled. irq falls in the following cycle.
- Reset asserted mid-debounce clears cnt and cand immediately. Debouncing restarts from the synchronizer after release.
- Values settled at power-up are not assumed: after reset, switches that are not all-zero produce one accept event.

## Test plan
- All tests use DEBOUNCE_CYCLES = 4.
- Power-up: switch = 8'h4A, reset low 3 cycles, then released.
  - During reset: irq = 0, rdata = 0 at all addrs.
  - addr0 reads 0x4A after edge 7 and not before; status = 0x1; addr2 = 0x4A.
- Glitch: from stable 0x4A, drive 0x4B for 3 cycles, then 0x4A.
  - stable stays 0x4A, pending unchanged, cnt returns to 0.
- Bounce: alternate 0x00/0xFF every cycle for 10 cycles, then hold 0xFF.
  - addr0 becomes 0xFF exactly at edge 7 after the last change; only one accept event.
- IRQ path:
  - Write addr1 wdata = 0x2 with pending = 1: irq = 1, status = 0x3.
  - rd at addr2: status = 0x2 after the edge, irq = 0.
- Overrun: accept 0x10, then 0x20 without clearing.
  - status = 0x7, snapshot = 0x20.
  - Write addr1 wdata = 0x3: status = 0x2.
- Simultaneous events and reset:
  - W1C on the same edge as an accept event: status bit0 = 1, bit2 = 0.
  - reset pulsed low while cnt = 2: all registers 0; the value is re-accepted 7 edges after release.
